// File: rtl/alu_ctrl_pkg.sv
// ALUctrl code table, FSM state encoding and shared types for the execute stage.
// Pure declarations; no timing or flow-control behaviour.
// Shared by the combinational core and the sequencing unit.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD     = 4'h0;
    localparam logic [3:0] ALU_SUB     = 4'h1;
    localparam logic [3:0] ALU_AND     = 4'h2;
    localparam logic [3:0] ALU_OR      = 4'h3;
    localparam logic [3:0] ALU_XOR     = 4'h5;
    localparam logic [3:0] ALU_NOR     = 4'h6;
    localparam logic [3:0] ALU_SLL     = 4'h7;
    localparam logic [3:0] ALU_SRL     = 4'h8;
    localparam logic [3:0] ALU_SRA     = 4'h9;
    localparam logic [3:0] ALU_SLT     = 4'hC;
    localparam logic [3:0] ALU_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic ovf;
        logic illegal;
    } flags_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU ops with signed-overflow and illegal-code detection.
// Latency: purely combinational.
// Backpressure: none; the caller registers the outputs.
import alu_ctrl_pkg::*;

module alu_comb_core #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] result,
    output flags_t          flags
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    always_comb begin
        result        = '0;
        flags         = '0;
        case (ctrl)
            ALU_ADD: begin
                result    = sum;
                flags.ovf = (src_a[XLEN-1] == src_b[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
            end
            ALU_SUB: begin
                result    = diff;
                flags.ovf = (src_a[XLEN-1] != src_b[XLEN-1]) && (diff[XLEN-1] != src_a[XLEN-1]);
            end
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_NOR: result = ~(src_a | src_b);
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            // Shifts are legal but sequenced bit-serially by the caller.
            ALU_SLL, ALU_SRL, ALU_SRA: result = '0;
            default: flags.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, bit-serial shifts (1 bit per cycle).
// Latency: 1 cycle for non-shifts and shamt==0, 1+shamt cycles for other shifts.
// Backpressure: result held until out_ready; in_ready low while shifting or while stalled.
import alu_ctrl_pkg::*;

module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [SHW-1:0]  shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            ovf,
    output logic            illegal
);

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_nxt;
    logic [SHW-1:0]  cnt;
    logic [3:0]      sh_op;
    logic [XLEN-1:0] core_res;
    flags_t          core_flags;
    logic            accept;

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .ctrl   (ctrl),
        .src_a  (src_a),
        .src_b  (src_b),
        .result (core_res),
        .flags  (core_flags)
    );

    always_comb begin
        acc_nxt = acc;
        case (sh_op)
            ALU_SLL: acc_nxt = acc << 1;
            ALU_SRL: acc_nxt = acc >> 1;
            default: acc_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            sh_op     <= ALU_SLL;
        end else begin
            case (state)
                ST_SHIFT: begin
                    acc <= acc_nxt;
                    cnt <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= acc_nxt;
                        zero      <= (acc_nxt == '0);
                        ovf       <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_shift(ctrl)) begin
                            ovf     <= 1'b0;
                            illegal <= 1'b0;
                            if (shamt == '0) begin
                                state     <= ST_DONE;
                                out_valid <= 1'b1;
                                result    <= src_b;
                                zero      <= (src_b == '0);
                            end else begin
                                // Operands are captured here so ID/EX may move on immediately.
                                state     <= ST_SHIFT;
                                out_valid <= 1'b0;
                                acc       <= src_b;
                                cnt       <= shamt;
                                sh_op     <= ctrl;
                            end
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            result    <= core_res;
                            zero      <= (core_res == '0);
                            ovf       <= core_flags.ovf;
                            illegal   <= core_flags.illegal;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued on acceptance, compared on retire.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic        ill;
        logic        ovf;
        logic        zero;
        logic [31:0] res;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   prev_pop = 0;
    int   last_pop = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t        e;
        logic [32:0] w;
        e = '0;
        w = '0;
        case (c)
            4'b0000: begin w = {a[31], a} + {b[31], b}; e.res = w[31:0]; e.ovf = w[32] ^ w[31]; end
            4'b0001: begin w = {a[31], a} - {b[31], b}; e.res = w[31:0]; e.ovf = w[32] ^ w[31]; end
            4'b0010: e.res = a & b;
            4'b0011: e.res = a | b;
            4'b0101: e.res = a ^ b;
            4'b0110: e.res = ~(a | b);
            4'b0111: e.res = b << sh;
            4'b1000: e.res = b >> sh;
            4'b1001: e.res = 32'($signed(b) >>> sh);
            4'b1100: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result",  result,  mon_e.res);
                check("zero",    zero,    mon_e.zero);
                check("ovf",     ovf,     mon_e.ovf);
                check("illegal", illegal, mon_e.ill);
            end
            prev_pop = last_pop;
            last_pop = cyc;
        end
    end

    // Offer one op; on a stalled cycle release backpressure so the bench cannot deadlock.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output int stalls);
        ctrl     = c;
        src_a    = a;
        src_b    = b;
        shamt    = sh;
        in_valid = 1'b1;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            if (stalls > 100) begin
                check("accept_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(c, a, b, sh));
    endtask

    task automatic wait_valid(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (!in_ready) busy++;
            if (out_valid) break;
            if (lat > 100) begin
                check("valid_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s1, s2, lat, busy, seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = 4'h0;
        src_a     = '0;
        src_b     = '0;
        shamt     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result",    result,    32'd0);
        check("rst_zero",      zero,      1'b0);
        check("rst_ovf",       ovf,       1'b0);
        check("rst_illegal",   illegal,   1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        step();

        // ADD overflow, latency 1
        send(4'b0000, 32'h7FFF_FFFF, 32'h1, 5'd0, s1);
        wait_valid(lat, busy);
        check("add_lat", lat, 1);
        step();

        // SUB then SLT back-to-back with continuous ready
        send(4'b0001, 32'd5, 32'd5, 5'd0, s1);
        send(4'b1100, 32'hFFFF_FFFF, 32'd1, 5'd0, s2);
        check("b2b_rdy1", s1, 0);
        check("b2b_rdy2", s2, 0);
        @(negedge clk);
        #1;
        check("b2b_spacing", last_pop - prev_pop, 1);
        step();

        // Shifts: SRA 4, SLL 31, SRL 0
        send(4'b1001, 32'h0, 32'h8000_0000, 5'd4, s1);
        wait_valid(lat, busy);
        check("sra_lat", lat, 5);
        check("sra_busy", busy, 4);
        step();
        send(4'b0111, 32'h0, 32'h1, 5'd31, s1);
        wait_valid(lat, busy);
        check("sll_lat", lat, 32);
        step();
        send(4'b1000, 32'h0, 32'hDEAD_BEEF, 5'd0, s1);
        wait_valid(lat, busy);
        check("srl0_lat", lat, 1);
        step();

        // Backpressure: XOR held 5 cycles while an ADD is offered
        out_ready = 1'b0;
        send(4'b0101, 32'hF0, 32'hFF, 5'd0, s1);
        ctrl     = 4'b0000;
        src_a    = 32'd2;
        src_b    = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid",  out_valid, 1'b1);
            check("bp_result", result,    32'h0000_000F);
            check("bp_ready",  in_ready,  1'b0);
        end
        step();
        out_ready = 1'b1;
        send(4'b0000, 32'd2, 32'd3, 5'd0, s1);
        check("bp_release", s1, 0);
        step();

        // Illegal codes
        send(4'b1111, 32'd1, 32'd1, 5'd0, s1);
        send(4'b0100, 32'd1, 32'd1, 5'd0, s1);
        step();

        // Reset in the middle of a long shift discards it
        send(4'b0111, 32'h0, 32'h1, 5'd20, s1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_ready",  in_ready,  1'b1);
        check("mid_rst_valid",  out_valid, 1'b0);
        check("mid_rst_result", result,    32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_silent", seen, 0);
        step();
        send(4'b0000, 32'd40, 32'd2, 5'd0, s1);

        // Random mix with random backpressure and idle gaps
        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra, rb;
            ra = (n % 7 == 0) ? 32'h8000_0000 : $urandom;
            rb = (n % 5 == 0) ? ra : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            send(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 7)), s1);
            if ($urandom_range(0, 3) == 0) step();
        end

        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
